noc_inject_arbiter: RTL

- Round-robin arbiter that shares one mesh-node injection port between N local requesters (PEs or DMA engines) attached to the same router.
- Each requester presents single-flit packets of {dest_y, dest_x, payload} using valid/ready.
- The arbiter forwards one packet per cycle through a registered output stage into the router's PE input.
- It keeps grant statistics that the bench uses to check fairness.

---
 rtl/noc_inject_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter sharing one router injection port among N requesters.
// One registered output slice; full throughput with per-requester grant counters.
module noc_inject_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned data_width  = 256,
  parameter int unsigned x_size      = 1,
  parameter int unsigned y_size      = 1,
  parameter int unsigned total_width = x_size + y_size + data_width,
  parameter int unsigned cnt_width   = 16,
  localparam int unsigned gid_w      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               i_valid,
  input  logic [N*total_width-1:0]   i_data,
  output logic [N-1:0]               o_ready,
  output logic                       o_valid,
  output logic [total_width-1:0]     o_data,
  input  logic                       i_ready,
  output logic [gid_w-1:0]           o_grant_id,
  output logic [N*cnt_width-1:0]     o_grant_cnt
);

  logic                   ld;
  logic                   found;
  logic                   grant;
  logic [gid_w-1:0]       win;
  logic [gid_w-1:0]       ptr;
  logic [2*N-1:0]         req2;
  logic [total_width-1:0] sel_flit;
  logic [cnt_width-1:0]   cnt [N];

  // Double-width masked priority search: first valid strictly after ptr, wrapping.
  always_comb begin
    ld    = !o_valid || i_ready;
    req2  = {i_valid, i_valid};
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (!found && req2[k] && (k > int'(ptr))) begin
        found = 1'b1;
        win   = gid_w'(k % N);
      end
    end
    grant = ld && found && !rst;
  end

  // Winner flit select and one-hot accept.
  always_comb begin
    sel_flit = '0;
    o_ready  = '0;
    for (int k = 0; k < N; k++) begin
      if (win == gid_w'(k)) begin
        sel_flit   = i_data[k*total_width +: total_width];
        o_ready[k] = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_grant_id <= '0;
      ptr        <= gid_w'(N - 1);
      for (int k = 0; k < N; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      // A drain with no new winner empties the slice; a load refills it.
      if (ld) begin
        o_valid <= found;
      end
      if (grant) begin
        o_data     <= sel_flit;
        o_grant_id <= win;
        ptr        <= win;
      end
      for (int k = 0; k < N; k++) begin
        if (grant && (win == gid_w'(k))) begin
          cnt[k] <= cnt[k] + cnt_width'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt_out
    assign o_grant_cnt[g*cnt_width +: cnt_width] = cnt[g];
  end

endmodule
